// File: rtl/raster_gen_pkg.sv
// raster_pkg: shared types for the raster pixel source.
// It holds the frame-sequencer state encoding and the pattern select codes.
package raster_pkg;

  // Frame sequencer states. The ST_ prefix keeps them apart from the
  // HBLANK/VBLANK parameter names.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_HBLANK = 2'd2,
    ST_VBLANK = 2'd3
  } state_t;

  localparam logic [1:0] PAT_RAMP  = 2'd0;
  localparam logic [1:0] PAT_HGRAD = 2'd1;
  localparam logic [1:0] PAT_CHECK = 2'd2;
  localparam logic [1:0] PAT_CONST = 2'd3;

endpackage

// File: rtl/raster_timing.sv
// raster_timing: frame sequencer with the h/v/blank counters.
// All outputs describe the cycle that follows the next clock edge. They come
// from the next-state logic, so the parent can register its pixel outputs and
// still show pixel (0,0) one cycle after en is sampled.
module raster_timing import raster_pkg::*; #(
  parameter int LINE_WIDTH = 640,
  parameter int LINE_COUNT = 480,
  parameter int HBLANK     = 16,
  parameter int VBLANK     = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  output logic [$clog2(LINE_WIDTH)-1:0] h_nxt,
  output logic [$clog2(LINE_COUNT)-1:0] v_nxt,
  output logic                          act_nxt,
  output logic                          sof_nxt,
  output logic                          eol_nxt,
  output logic                          eof_nxt,
  output logic                          busy_nxt
);

  localparam int HW     = $clog2(LINE_WIDTH);
  localparam int VW     = $clog2(LINE_COUNT);
  localparam int LP     = LINE_WIDTH + HBLANK;
  localparam int VB_CYC = VBLANK * LP;
  localparam int BW     = $clog2(VB_CYC + HBLANK + 2);

  localparam logic [HW-1:0] H_LAST  = HW'(LINE_WIDTH - 1);
  localparam logic [VW-1:0] V_LAST  = VW'(LINE_COUNT - 1);
  localparam logic [BW-1:0] HB_LAST = BW'((HBLANK > 0) ? HBLANK - 1 : 0);
  localparam logic [BW-1:0] VB_LAST = BW'((VB_CYC > 0) ? VB_CYC - 1 : 0);

  state_t        state, state_n;
  logic [HW-1:0] h, h_n;
  logic [VW-1:0] v, v_n;
  logic [BW-1:0] bcnt, bcnt_n;
  logic          wrap;

  // State and counter registers; reset always lands in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      h     <= '0;
      v     <= '0;
      bcnt  <= '0;
    end else begin
      state <= state_n;
      h     <= h_n;
      v     <= v_n;
      bcnt  <= bcnt_n;
    end
  end

  // Next-state logic. wrap marks the end of a frame, where en picks between
  // an immediate new frame and IDLE.
  always_comb begin
    state_n = state;
    h_n     = h;
    v_n     = v;
    bcnt_n  = bcnt;
    wrap    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (en) begin
          state_n = ST_ACTIVE;
          h_n     = '0;
          v_n     = '0;
        end
      end
      ST_ACTIVE: begin
        if (h == H_LAST) begin
          h_n = '0;
          if (HBLANK > 0) begin
            state_n = ST_HBLANK;
            bcnt_n  = '0;
          end else if (v != V_LAST) begin
            v_n = v + 1'b1;
          end else if (VBLANK > 0) begin
            state_n = ST_VBLANK;
            bcnt_n  = '0;
          end else begin
            wrap = 1'b1;
          end
        end else begin
          h_n = h + 1'b1;
        end
      end
      ST_HBLANK: begin
        if (bcnt == HB_LAST) begin
          if (v != V_LAST) begin
            state_n = ST_ACTIVE;
            h_n     = '0;
            v_n     = v + 1'b1;
          end else if (VBLANK > 0) begin
            state_n = ST_VBLANK;
            bcnt_n  = '0;
          end else begin
            wrap = 1'b1;
          end
        end else begin
          bcnt_n = bcnt + 1'b1;
        end
      end
      default: begin
        if (bcnt == VB_LAST) wrap = 1'b1;
        else                 bcnt_n = bcnt + 1'b1;
      end
    endcase
    if (wrap) begin
      state_n = en ? ST_ACTIVE : ST_IDLE;
      h_n     = '0;
      v_n     = '0;
      bcnt_n  = '0;
    end
  end

  // Strobes for the upcoming cycle.
  always_comb begin
    h_nxt    = h_n;
    v_nxt    = v_n;
    act_nxt  = (state_n == ST_ACTIVE);
    sof_nxt  = act_nxt && (h_n == '0) && (v_n == '0);
    eol_nxt  = act_nxt && (h_n == H_LAST);
    eof_nxt  = eol_nxt && (v_n == V_LAST);
    busy_nxt = (state_n != ST_IDLE);
  end

endmodule

// File: rtl/raster_gen.sv
// raster_gen: free-running raster pixel source with blanking and markers.
// It latches the pattern at frame start, computes the pixel and registers all
// outputs.
// Optional macro RASTER_GEN_BORDER_EN forces the outer frame border pixels to
// all-ones, for every pattern.
module raster_gen import raster_pkg::*; #(
  parameter int LINE_WIDTH = 640,
  parameter int LINE_COUNT = 480,
  parameter int DATA_WIDTH = 8,
  parameter int HBLANK     = 16,
  parameter int VBLANK     = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [1:0]            pattern,
  input  logic [DATA_WIDTH-1:0] const_val,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  sof,
  output logic                  eol,
  output logic                  eof,
  output logic                  busy
);

  localparam int HW = $clog2(LINE_WIDTH);
  localparam int VW = $clog2(LINE_COUNT);
  localparam int PW = $clog2(LINE_WIDTH * LINE_COUNT) + 1;
  // The ramp is summed at full frame-index width, then truncated.
  localparam int RW = (PW > DATA_WIDTH) ? PW : DATA_WIDTH;

  logic [HW-1:0]         h_nxt;
  logic [VW-1:0]         v_nxt;
  logic                  act_nxt, sof_nxt, eol_nxt, eof_nxt, busy_nxt;
  logic [1:0]            pat_q, pat_eff;
  logic [DATA_WIDTH-1:0] cv_q, cv_eff, pix;
  logic                  chk_bit;

  raster_timing #(
    .LINE_WIDTH (LINE_WIDTH),
    .LINE_COUNT (LINE_COUNT),
    .HBLANK     (HBLANK),
    .VBLANK     (VBLANK)
  ) u_timing (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .h_nxt    (h_nxt),
    .v_nxt    (v_nxt),
    .act_nxt  (act_nxt),
    .sof_nxt  (sof_nxt),
    .eol_nxt  (eol_nxt),
    .eof_nxt  (eof_nxt),
    .busy_nxt (busy_nxt)
  );

  // Pixel (0,0) is produced on the same edge that latches the pattern, so it
  // takes the live inputs. Later pixels use the latched copy.
  always_comb begin
    pat_eff = sof_nxt ? pattern   : pat_q;
    cv_eff  = sof_nxt ? const_val : cv_q;
    // Bit 3 of h and v; a counter narrower than 4 bits always reads 0 here.
    chk_bit = (|(h_nxt & HW'(8))) ^ (|(v_nxt & VW'(8)));
    case (pat_eff)
      PAT_RAMP:  pix = DATA_WIDTH'(RW'(h_nxt) + RW'(v_nxt) * RW'(LINE_WIDTH));
      PAT_HGRAD: pix = DATA_WIDTH'(h_nxt);
      PAT_CHECK: pix = chk_bit ? '1 : '0;
      default:   pix = cv_eff;
    endcase
`ifdef RASTER_GEN_BORDER_EN
    if (h_nxt == '0 || h_nxt == HW'(LINE_WIDTH - 1) ||
        v_nxt == '0 || v_nxt == VW'(LINE_COUNT - 1))
      pix = '1;
`endif
  end

  // Output and pattern-latch registers; data_out is 0 outside active pixels.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      sof        <= 1'b0;
      eol        <= 1'b0;
      eof        <= 1'b0;
      busy       <= 1'b0;
      pat_q      <= PAT_RAMP;
      cv_q       <= '0;
    end else begin
      data_out   <= act_nxt ? pix : '0;
      data_valid <= act_nxt;
      sof        <= sof_nxt;
      eol        <= eol_nxt;
      eof        <= eof_nxt;
      busy       <= busy_nxt;
      if (sof_nxt) begin
        pat_q <= pattern;
        cv_q  <= const_val;
      end
    end
  end

endmodule
